input_stream_buffer: RTL and testbench
======================================

# input_stream_buffer

AXI4-Stream slave that accepts 32-bit beats from the DMA/host side and packs every four beats into one 128-bit word for the systolic array's input load port. It is the ingress counterpart of the 128-to-32 serializer on the result path and uses the same lane order: beat 0 lands in bits [31:0]. A one-word assembly register plus a one-word holding register sustain one beat per cycle. Backpressure from the array is absorbed without any combinational path from `rd_ready` to `s_axis_ready`.

## Interface
- DATA_W, 32, stream beat width
- BEATS, 4, beats per packed word; WORD_W = DATA_W*BEATS = 128
- axi_clk  in  1  clock, all logic on rising edge
- axi_rst_n  in  1  reset, asynchronous, active-low
- s_axis_valid  in  1  beat valid
- s_axis_data  in  32  beat payload
- s_axis_last  in  1  final beat of frame
- s_axis_ready  out  1  beat accepted when valid && ready; registered output
- rd_valid  out  1  packed word available
- rd_data  out  128  packed word, beat i in bits [32i+31:32i]
- rd_last  out  1  word contains frame's last beat
- rd_beats  out  3  number of valid lanes in rd_data, 1..4
- rd_ready  in  1  consumer takes word when rd_valid && rd_ready

## Operation
- Reset values: s_axis_ready=0, rd_valid=0, rd_data=0, rd_last=0, rd_beats=0; internal cnt=0, asm_full=0, assembly register=0.
- s_axis_ready is 1 from the first edge after reset release. Thereafter it is the registered value of !asm_full_next.
- Accepted beat with cnt=k writes lane k of the assembly register and increments cnt.
- A word completes on an accepted beat when cnt=3 or s_axis_last=1.
- Early completion (last at cnt<3): lanes above k are zero-filled, rd_beats=k+1, rd_last=1.
- Completion at cnt=3: rd_beats=4, rd_last=s_axis_last.
- cnt returns to 0 after every completion. The next beat starts a new word at lane 0.
- Hold free this cycle means rd_valid=0 or rd_ready=1.
- On completion with hold free, the word, rd_last and rd_beats load the holding outputs at the same edge, and rd_valid=1.
- On completion with hold not free, the word parks in the assembly register with asm_full=1. s_axis_ready drops at that edge.
- While asm_full=1 and hold is free, the parked word moves to the holding outputs. asm_full clears and s_axis_ready returns to 1 at the same edge.
- Drain without refill: rd_valid clears. rd_data/rd_last/rd_beats retain their last values.
- rd_data, rd_last and rd_beats are stable while rd_valid=1 and rd_ready=0.
- A beat with s_axis_ready=0 is not accepted. Data, cnt and lanes are unchanged.
- Asynchronous reset mid-word discards partial lanes and any held word. All outputs go to their reset values immediately.

## Timing
- Latency: the completing beat accepted at edge N gives rd_valid=1 after edge N.
- Throughput: one beat per cycle, one word per 4 cycles, sustained while rd_ready=1.
- Backpressure: with rd_ready=0, at most 4 further beats are accepted after the held word: 3 partial plus 1 completing, which parks. s_axis_ready then falls.
- s_axis_ready depends only on registers. There is no combinational path from any input.
- Simultaneous drain of the held word and completion of a new word at the same edge: the new word loads the holding outputs. rd_valid stays 1 with no bubble.

## Test plan
- Reset, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (last on beat 4) with rd_ready=1 -> rd_valid after edge 4, rd_data=0x44444444_33333333_22222222_11111111, rd_beats=4, rd_last=1.
- Continuous stream of 12 beats with valid=1 and rd_ready=1 -> s_axis_ready never drops, 3 words on consecutive 4-cycle boundaries, no lost beats.
- rd_ready=0 for 20 cycles with valid=1 -> word1 held. Beats 5-8 accepted, word2 parks, s_axis_ready=0 from edge 8. On rd_ready=1, word1 drains, word2 moves to hold, ready returns to 1 at that same edge.
- Frame of 2 beats 0xAAAA0001, 0xAAAA0002 with last on beat 2 -> rd_data=0x0..0_AAAA0002_AAAA0001, rd_beats=2, rd_last=1. The next beat lands in lane 0.
- rd_ready toggling 1/0 per cycle with random s_axis_valid -> scoreboard shows packed words in order, rd_data stable while stalled.
- Assert axi_rst_n low after 2 beats, release, send 4 beats -> the output word contains only the post-reset beats, with no stale lanes.

Source files
------------

// File: rtl/input_stream_buffer_if.sv
// Stream ingress bundle: 32-bit AXI4-Stream beats in, packed
// 128-bit words out toward the systolic array load port.
interface input_stream_buffer_if #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    localparam int WORD_W = DATA_W * BEATS;
    localparam int BW     = $clog2(BEATS + 1);

    logic              s_axis_valid;
    logic [DATA_W-1:0] s_axis_data;
    logic              s_axis_last;
    logic              s_axis_ready;

    logic              rd_valid;
    logic [WORD_W-1:0] rd_data;
    logic              rd_last;
    logic [BW-1:0]     rd_beats;
    logic              rd_ready;

    modport slave (
        input  s_axis_valid, s_axis_data, s_axis_last, rd_ready,
        output s_axis_ready, rd_valid, rd_data, rd_last, rd_beats
    );

    modport master (
        output s_axis_valid, s_axis_data, s_axis_last, rd_ready,
        input  s_axis_ready, rd_valid, rd_data, rd_last, rd_beats
    );
endinterface

// File: rtl/input_stream_buffer.sv
// Packs 32-bit stream beats into 128-bit words, lane 0 first.
// Assembly register plus holding register keep one beat per cycle.
module input_stream_buffer #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input logic                  axi_clk,
    input logic                  axi_rst_n,
    input_stream_buffer_if.slave bus
);
    localparam int WORD_W = DATA_W * BEATS;
    localparam int CW     = $clog2(BEATS);
    localparam int BW     = $clog2(BEATS + 1);

    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] asm_q;
    logic              asm_full;
    logic              asm_last;
    logic [BW-1:0]     asm_beats;

    logic              ready_q;
    logic              rd_valid_q;
    logic [WORD_W-1:0] rd_data_q;
    logic              rd_last_q;
    logic [BW-1:0]     rd_beats_q;

    logic              accept;
    logic              hold_free;
    logic              complete;
    logic              asm_full_next;
    logic [WORD_W-1:0] comp_word;
    logic [BW-1:0]     comp_beats;

    always_comb begin
        accept     = bus.s_axis_valid && ready_q;
        hold_free  = !rd_valid_q || bus.rd_ready;
        complete   = accept &&
                     ((cnt == CW'(BEATS - 1)) || bus.s_axis_last);
        comp_beats = BW'(cnt) + BW'(1);
        // lanes above the completing one are zero-filled
        comp_word  = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (CW'(i) < cnt)
                comp_word[i*DATA_W +: DATA_W] = asm_q[i*DATA_W +: DATA_W];
            else if (CW'(i) == cnt)
                comp_word[i*DATA_W +: DATA_W] = bus.s_axis_data;
        end
        if (asm_full)
            asm_full_next = !hold_free;
        else
            asm_full_next = complete && !hold_free;
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            cnt        <= '0;
            asm_q      <= '0;
            asm_full   <= 1'b0;
            asm_last   <= 1'b0;
            asm_beats  <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_beats_q <= '0;
        end else begin
            ready_q  <= !asm_full_next;
            asm_full <= asm_full_next;

            if (accept) begin
                if (complete)
                    cnt <= '0;
                else
                    cnt <= cnt + CW'(1);

                if (complete && !hold_free) begin
                    asm_q     <= comp_word;
                    asm_last  <= bus.s_axis_last;
                    asm_beats <= comp_beats;
                end else begin
                    for (int i = 0; i < BEATS; i++)
                        if (CW'(i) == cnt)
                            asm_q[i*DATA_W +: DATA_W] <= bus.s_axis_data;
                end
            end

            // parked word has priority; it cannot coexist with a completion
            if (asm_full && hold_free) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= asm_q;
                rd_last_q  <= asm_last;
                rd_beats_q <= asm_beats;
            end else if (complete && hold_free) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= comp_word;
                rd_last_q  <= bus.s_axis_last;
                rd_beats_q <= comp_beats;
            end else if (bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axis_ready = ready_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.rd_beats     = rd_beats_q;

endmodule

// File: tb/tb_input_stream_buffer.sv
// Bench for input_stream_buffer: queue-based packing model checked
// every cycle, plus directed literal checks.
module tb_input_stream_buffer;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;

    logic axi_clk = 1'b0;
    logic axi_rst_n = 1'b0;
    always #5 axi_clk = ~axi_clk;

    input_stream_buffer_if #(.DATA_W(DATA_W), .BEATS(BEATS)) bus ();

    input_stream_buffer #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .axi_clk   (axi_clk),
        .axi_rst_n (axi_rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [2:0]   beats;
    } word_t;

    int tests = 0;
    int fails = 0;
    word_t       exp_q[$];
    logic [31:0] part_q[$];
    int          pop_cyc[$];
    int          words_out = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          done = 0;

    logic         stalled = 1'b0;
    logic [127:0] st_data;
    logic         st_last;
    logic [2:0]   st_beats;
    word_t        mw;
    logic [127:0] wd;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge axi_clk) cyc <= cyc + 1;

    // Model: accepted beats accumulate; 4 beats or last closes a word.
    always @(negedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            exp_q.delete();
            part_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", bus.rd_valid, 1'b1);
                check("stall_data", bus.rd_data, st_data);
                check("stall_meta", {bus.rd_last, bus.rd_beats},
                      {st_last, st_beats});
            end
            stalled  = bus.rd_valid && !bus.rd_ready;
            st_data  = bus.rd_data;
            st_last  = bus.rd_last;
            st_beats = bus.rd_beats;

            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none",
                             bus.rd_data);
                end else begin
                    mw = exp_q.pop_front();
                    check("word_data", bus.rd_data, mw.data);
                    check("word_last", bus.rd_last, mw.last);
                    check("word_beats", bus.rd_beats, mw.beats);
                    words_out++;
                    pop_cyc.push_back(cyc);
                end
            end

            if (bus.s_axis_valid && bus.s_axis_ready) begin
                part_q.push_back(bus.s_axis_data);
                if (part_q.size() == BEATS || bus.s_axis_last) begin
                    wd = '0;
                    for (int i = 0; i < part_q.size(); i++)
                        wd[i*32 +: 32] = part_q[i];
                    mw.data  = wd;
                    mw.last  = bus.s_axis_last;
                    mw.beats = 3'(part_q.size());
                    exp_q.push_back(mw);
                    part_q.delete();
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit took;
        took = 1'b0;
        bus.s_axis_valid = 1'b1;
        bus.s_axis_data  = d;
        bus.s_axis_last  = l;
        for (int n = 0; n < 200 && !took; n++) begin
            @(negedge axi_clk);
            took = bus.s_axis_ready;
            if (!took) stall_cnt++;
            @(posedge axi_clk);
            #1;
        end
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0h not accepted, required accept", d);
        end
    endtask

    task automatic idle(input int n);
        bus.s_axis_valid = 1'b0;
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int idx;
        bit took;
        bus.s_axis_valid = 1'b0;
        bus.s_axis_data  = '0;
        bus.s_axis_last  = 1'b0;
        bus.rd_ready     = 1'b1;

        // reset state
        #12;
        check("rst_ready", bus.s_axis_ready, 1'b0);
        check("rst_valid", bus.rd_valid, 1'b0);
        check("rst_data", bus.rd_data, 128'h0);
        check("rst_last", bus.rd_last, 1'b0);
        check("rst_beats", bus.rd_beats, 3'd0);
        @(posedge axi_clk);
        #1;
        axi_rst_n = 1'b1;
        #1;
        check("ready_pre_edge", bus.s_axis_ready, 1'b0);
        @(posedge axi_clk);
        #1;
        check("ready_post_edge", bus.s_axis_ready, 1'b1);

        // basic 4-beat word
        send_beat(32'h11111111, 1'b0);
        send_beat(32'h22222222, 1'b0);
        send_beat(32'h33333333, 1'b0);
        send_beat(32'h44444444, 1'b1);
        bus.s_axis_valid = 1'b0;
        check("t1_valid", bus.rd_valid, 1'b1);
        check("t1_data", bus.rd_data,
              128'h44444444_33333333_22222222_11111111);
        check("t1_beats", bus.rd_beats, 3'd4);
        check("t1_last", bus.rd_last, 1'b1);
        idle(2);
        check("t1_drained", bus.rd_valid, 1'b0);
        check("t1_retain", bus.rd_data,
              128'h44444444_33333333_22222222_11111111);

        // continuous 12 beats
        pop_cyc.delete();
        stall_cnt = 0;
        w0 = words_out;
        for (int i = 0; i < 12; i++)
            send_beat(32'h5000_0000 + 32'(i), i == 11);
        idle(3);
        check("t2_no_stall", stall_cnt, 0);
        check("t2_words", words_out - w0, 3);
        if (pop_cyc.size() == 3) begin
            check("t2_gap1", pop_cyc[1] - pop_cyc[0], 4);
            check("t2_gap2", pop_cyc[2] - pop_cyc[1], 4);
        end else begin
            check("t2_pop_count", pop_cyc.size(), 3);
        end

        // backpressure
        bus.rd_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 20; c++) begin
            bus.s_axis_valid = 1'b1;
            bus.s_axis_data  = 32'hB000_0000 + 32'(idx);
            bus.s_axis_last  = 1'b0;
            @(negedge axi_clk);
            took = bus.s_axis_ready;
            @(posedge axi_clk);
            #1;
            if (took) begin
                idx++;
                if (idx == 9) check("t3_ready_drop", bus.s_axis_ready, 1'b0);
            end
        end
        bus.s_axis_valid = 1'b0;
        check("t3_accepted", idx - 1, 8);
        check("t3_ready_low", bus.s_axis_ready, 1'b0);
        check("t3_held_valid", bus.rd_valid, 1'b1);
        check("t3_held_data", bus.rd_data,
              128'hB0000004_B0000003_B0000002_B0000001);
        bus.rd_ready = 1'b1;
        @(posedge axi_clk);
        #1;
        check("t3_ready_back", bus.s_axis_ready, 1'b1);
        check("t3_valid_cont", bus.rd_valid, 1'b1);
        check("t3_word2", bus.rd_data,
              128'hB0000008_B0000007_B0000006_B0000005);
        check("t3_word2_meta", {bus.rd_last, bus.rd_beats}, 4'b0_100);
        @(posedge axi_clk);
        #1;
        check("t3_drained", bus.rd_valid, 1'b0);
        check("t3_retain", bus.rd_data,
              128'hB0000008_B0000007_B0000006_B0000005);

        // short frame then lane 0 restart
        send_beat(32'hAAAA0001, 1'b0);
        send_beat(32'hAAAA0002, 1'b1);
        bus.s_axis_valid = 1'b0;
        check("t4_data", bus.rd_data,
              128'h00000000_00000000_AAAA0002_AAAA0001);
        check("t4_beats", bus.rd_beats, 3'd2);
        check("t4_last", bus.rd_last, 1'b1);
        send_beat(32'hC1, 1'b0);
        send_beat(32'hC2, 1'b0);
        send_beat(32'hC3, 1'b0);
        send_beat(32'hC4, 1'b1);
        bus.s_axis_valid = 1'b0;
        check("t4_next_data", bus.rd_data,
              128'h000000C4_000000C3_000000C2_000000C1);

        // toggling rd_ready with sparse valid
        done = 0;
        fork
            begin
                for (int g = 0; g < 2000 && !done; g++) begin
                    @(posedge axi_clk);
                    #1;
                    bus.rd_ready = ~bus.rd_ready;
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    if (i == 23 || $urandom_range(0, 1) == 1)
                        send_beat(32'hD000_0000 + 32'(i),
                                  (i % 5 == 4) || (i == 23));
                    else
                        idle(1);
                end
                bus.s_axis_valid = 1'b0;
                done = 1;
            end
        join
        bus.rd_ready = 1'b1;
        idle(4);
        check("t5_exp_empty", exp_q.size(), 0);
        check("t5_part_empty", part_q.size(), 0);

        // reset mid-word
        send_beat(32'hE1, 1'b0);
        send_beat(32'hE2, 1'b0);
        bus.s_axis_valid = 1'b0;
        #2;
        axi_rst_n = 1'b0;
        #1;
        check("t6_rst_ready", bus.s_axis_ready, 1'b0);
        check("t6_rst_valid", bus.rd_valid, 1'b0);
        check("t6_rst_data", bus.rd_data, 128'h0);
        check("t6_rst_last", bus.rd_last, 1'b0);
        check("t6_rst_beats", bus.rd_beats, 3'd0);
        @(posedge axi_clk);
        #1;
        axi_rst_n = 1'b1;
        @(posedge axi_clk);
        #1;
        send_beat(32'hF1, 1'b0);
        send_beat(32'hF2, 1'b0);
        send_beat(32'hF3, 1'b0);
        send_beat(32'hF4, 1'b1);
        bus.s_axis_valid = 1'b0;
        check("t6_data", bus.rd_data,
              128'h000000F4_000000F3_000000F2_000000F1);
        check("t6_beats", bus.rd_beats, 3'd4);

        idle(3);
        check("end_exp_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
